display_scan_scheduler: RTL and testbench

Sequencer that sits between the message memory and the LED decoder on the divided display clock. It fetches one character per digit from a read-latency-1 memory and drives the four active-low anodes with a blanking gap between digits to suppress ghosting. It also advances a scroll offset every `FRAMES_PER_STEP` refresh frames, producing a scrolling message. Its `char` output feeds the LED decoder directly.

---
 rtl/display_scan_scheduler_if.sv | 10 +
 rtl/display_scan_scheduler.sv | 162 ++++++++++++++++
 tb/tb_display_scan_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_scheduler_if.sv
// Character fetch bus between the scan scheduler and the message memory.
// Read latency is one cycle: mem_data is valid the cycle after mem_rd_en.
interface display_scan_scheduler_if;
  logic       mem_rd_en;
  logic [3:0] mem_addr;
  logic [3:0] mem_data;

  modport master (output mem_rd_en, output mem_addr, input mem_data);
  modport slave  (input mem_rd_en, input mem_addr, output mem_data);
endinterface

// File: rtl/display_scan_scheduler.sv
// Four-digit multiplexed display sequencer: fetches one character per digit,
// blanks between digits to suppress ghosting, and scrolls the message offset.
module display_scan_scheduler #(
  parameter int DIGIT_CYCLES    = 16,
  parameter int BLANK_CYCLES    = 2,
  parameter int FRAMES_PER_STEP = 64,
  parameter int MSG_LEN         = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            hold,
  display_scan_scheduler_if.master        mem,
  output logic [3:0]                      char,
  output logic                            an3,
  output logic                            an2,
  output logic                            an1,
  output logic                            an0,
  output logic                            frame_done,
  output logic [3:0]                      step
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int FC_W    = $clog2(FRAMES_PER_STEP) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, BLANK, SHOW} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        idx_reg, idx_next;
  logic [FC_W-1:0]   frame_cnt_reg, frame_cnt_next;
  logic [3:0]        step_reg, step_next;
  logic [3:0]        char_reg, char_next;
  logic [3:0]        an_reg, an_next;
  logic              rd_en_reg, rd_en_next;
  logic [3:0]        addr_reg, addr_next;
  logic              frame_done_reg, frame_done_next;
  logic              frame_end;
  logic [4:0]        addr_sum;
  logic [3:0]        an_dec;

  // State register; every output is a register loaded from the next-state decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      frame_cnt_reg  <= '0;
      step_reg       <= '0;
      char_reg       <= '0;
      an_reg         <= 4'b1111;
      rd_en_reg      <= 1'b0;
      addr_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      frame_cnt_reg  <= frame_cnt_next;
      step_reg       <= step_next;
      char_reg       <= char_next;
      an_reg         <= an_next;
      rd_en_reg      <= rd_en_next;
      addr_reg       <= addr_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Next-state: sequencing, digit index, frame counter and scroll offset.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    frame_cnt_next = frame_cnt_reg;
    step_next      = step_reg;
    frame_end      = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = FETCH;
          cnt_next   = '0;
          idx_next   = '0;
        end
        FETCH: begin
          state_next = BLANK;
          cnt_next   = '0;
        end
        BLANK: begin
          if (cnt_reg == CNT_W'(BLANK_CYCLES - 1)) begin
            state_next = SHOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt_reg == CNT_W'(DIGIT_CYCLES - 1)) begin
            state_next = FETCH;
            cnt_next   = '0;
            if (idx_reg == 2'd3) begin
              idx_next  = '0;
              frame_end = 1'b1;
              if (!hold) begin
                if (frame_cnt_reg == FC_W'(FRAMES_PER_STEP - 1)) begin
                  frame_cnt_next = '0;
                  step_next = (step_reg == 4'(MSG_LEN - 1)) ? 4'd0 : step_reg + 4'd1;
                end else begin
                  frame_cnt_next = frame_cnt_reg + FC_W'(1);
                end
              end
            end else begin
              idx_next = idx_reg + 2'd1;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Only one anode can decode low, and only while the next state is SHOW.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_dec[gi] = !((state_next == SHOW) && (idx_next == 2'(3 - gi)));
    end
  endgenerate

  assign addr_sum = {1'b0, step_next} + {3'b000, idx_next};

  // Output decode, registered above so outputs line up with the state they describe.
  always_comb begin
    an_next         = an_dec;
    rd_en_next      = (state_next == FETCH);
    addr_next       = addr_reg;
    frame_done_next = frame_end;
    char_next       = char_reg;
    if (state_next == FETCH)
      addr_next = 4'((addr_sum >= 5'(MSG_LEN)) ? addr_sum - 5'(MSG_LEN) : addr_sum);
    // Memory data arrives during the first BLANK cycle.
    if (enable && (state_reg == BLANK) && (cnt_reg == '0))
      char_next = mem.mem_data;
  end

  assign mem.mem_rd_en = rd_en_reg;
  assign mem.mem_addr  = addr_reg;
  assign char          = char_reg;
  assign an3           = an_reg[3];
  assign an2           = an_reg[2];
  assign an1           = an_reg[1];
  assign an0           = an_reg[0];
  assign frame_done    = frame_done_reg;
  assign step          = step_reg;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler: expected digit and frame events are
// queued up front and a monitor pops them as the display presents them.
`timescale 1ns/1ps
module tb_display_scan_scheduler;
  localparam int DC = 4, BC = 2, FPS = 2, ML = 6, FRAME = 28;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] char, step;
  logic       an3, an2, an1, an0, frame_done;
  logic       cut = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  typedef struct packed {
    logic       is_fd;
    logic [3:0] an;
    logic [3:0] ch;
    logic [3:0] st;
  } exp_t;
  exp_t exp_q[$];

  // Scroll offset shown in each frame: steps every 2 frames, frames 16..20 held.
  int         step_tab [0:25] = '{0,0,1,1,2,2,3,3,4,4,5,5,0,0,1,1,2,2,2,2,2,2,2,3,3,3};
  logic [3:0] an_tab   [0:3]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  display_scan_scheduler_if mem_bus();

  display_scan_scheduler #(
    .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .FRAMES_PER_STEP(FPS), .MSG_LEN(ML)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold), .mem(mem_bus),
    .char(char), .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .frame_done(frame_done), .step(step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_bus.mem_rd_en) mem_bus.mem_data <= mem_bus.mem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int k, input bit with_fd, input int ndig);
    exp_t e;
    if (with_fd) begin
      e = '{is_fd: 1'b1, an: 4'hF, ch: 4'h0, st: 4'(step_tab[k])};
      exp_q.push_back(e);
    end
    for (int i = 0; i < ndig; i++) begin
      e = '{is_fd: 1'b0, an: an_tab[i], ch: 4'((step_tab[k] + i) % ML), st: 4'(step_tab[k])};
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, {an3, an2, an1, an0}, 4'b1111);
    check({tag, "_char"}, char, 4'd0);
    check({tag, "_rd_en"}, mem_bus.mem_rd_en, 1'b0);
    check({tag, "_addr"}, mem_bus.mem_addr, 4'd0);
    check({tag, "_frame_done"}, frame_done, 1'b0);
    check({tag, "_step"}, step, 4'd0);
  endtask

  initial begin : monitor
    logic [3:0] an, prev_an, prev_ch;
    int gap, run, last_fd;
    exp_t e;
    prev_an = 4'hF; prev_ch = 4'h0; gap = 100; run = 0; last_fd = -1;
    forever begin
      @(negedge clk);
      an = {an3, an2, an1, an0};
      check("onehot_low", 32'($countones(~an) <= 1), 1);
      if (an != 4'hF) begin
        if (prev_an == 4'hF) begin
          check("blank_gap", 32'(gap >= BC), 1);
          check("digit_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("digit an=%b char=%0d step=%0d (want an=%b char=%0d step=%0d)",
                     an, char, step, e.an, e.ch, e.st);
            check("event_kind", e.is_fd, 1'b0);
            check("digit_an", an, e.an);
            check("digit_char", char, e.ch);
            check("digit_step", step, e.st);
          end
          run = 1;
        end else begin
          check("no_direct_switch", an, prev_an);
          check("char_stable", char, prev_ch);
          run++;
        end
        gap = 0;
      end else begin
        if (prev_an != 4'hF && !cut) check("dwell", run, DC);
        gap++;
      end
      if (frame_done) begin
        if (last_fd >= 0) check("frame_period", cyc - last_fd, FRAME);
        last_fd = cyc;
        check("fd_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("frame_done step=%0d (want %0d)", step, e.st);
          check("event_kind", e.is_fd, 1'b1);
          check("fd_step", step, e.st);
        end
      end
      prev_an = an;
      prev_ch = char;
    end
  end

  initial begin : stim
    for (int k = 0; k < 24; k++) push_frame(k, k > 0, 4);
    push_frame(24, 1'b1, 3);
    push_frame(25, 1'b0, 2);

    reset = 1'b0; enable = 1'b1; hold = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);                          // cycle 0: first FETCH
    check("first_rd_en", mem_bus.mem_rd_en, 1'b1);
    check("first_addr", mem_bus.mem_addr, 4'd0);

    repeat (453) @(negedge clk);             // frame 16, step 2
    hold = 1'b1;
    repeat (140) @(negedge clk);             // frame 21, after 5 held frame ends
    check("step_held", step, 4'd2);
    hold = 1'b0;

    repeat (96) @(negedge clk);
    cut = 1'b1;
    @(negedge clk);                          // frame 24, an1 shown
    enable = 1'b0;
    @(negedge clk);
    check("drop_an", {an3, an2, an1, an0}, 4'b1111);
    check("drop_rd_en", mem_bus.mem_rd_en, 1'b0);
    check("drop_frame_done", frame_done, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("idle_an", {an3, an2, an1, an0}, 4'b1111);
      check("idle_frame_done", frame_done, 1'b0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("restart_rd_en", mem_bus.mem_rd_en, 1'b1);
    check("restart_addr", mem_bus.mem_addr, 4'd3);
    check("restart_step", step, 4'd3);
    cut = 1'b0;

    repeat (10) @(negedge clk);
    cut = 1'b1;
    @(negedge clk);                          // an2 shown, step 3
    check("mid_step", step, 4'd3);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
